// File: rtl/uart_tx.sv
// UART transmitter with a one-entry holding register, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 8474
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_tvalid,
  input  logic [7:0] i_tdata,
  output logic       o_tready,
  output logic       o_uart_tx,
  output logic       o_busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [2:0]  state_q, state_d;
  logic        full_q, full_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic        tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  logic accept;
  logic load;
  logic baud_last;

  assign accept    = i_tvalid && !full_q;
  assign baud_last = (baud_q == BAUD_LAST);

  assign o_tready  = !full_q;
  assign o_uart_tx = tx_q;
  assign o_busy    = (state_q != IDLE) || full_q;

  always_comb begin
    state_d = state_q;
    full_d  = full_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    load    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (accept) begin
      hold_d = i_tdata;
      full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (full_q) load = 1'b1;
      end
      default: begin
        if (!baud_last) begin
          baud_d = baud_q + 16'd1;
        end else begin
          baud_d = '0;
          case (state_q)
            START: begin
              state_d = DATA;
              bit_d   = '0;
              tx_d    = shift_q[0];
            end
            DATA: begin
              if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state_d = PARITY;
                tx_d    = parity_q;
`else
                state_d = STOP;
                tx_d    = 1'b1;
`endif
              end else begin
                bit_d   = bit_q + 3'd1;
                shift_d = shift_q >> 1;
                tx_d    = shift_q[1];
              end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
`endif
            STOP: begin
              // A held byte chains straight into the next start bit.
              if (full_q) begin
                load = 1'b1;
              end else begin
                state_d = IDLE;
                tx_d    = 1'b1;
              end
            end
            default: begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          endcase
        end
      end
    endcase

    // load only fires with full set, so it never collides with an accept
    if (load) begin
      shift_d = hold_q;
      full_d  = 1'b0;
      state_d = START;
      tx_d    = 1'b0;
      baud_d  = '0;
      bit_d   = '0;
`ifdef UART_TX_PARITY_EN
      parity_d = ^hold_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      full_q  <= 1'b0;
      hold_q  <= '0;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4; expected line waveforms are hand-written frames.
// Build with UART_TX_PARITY_EN defined to exercise the parity variant.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int NVEC = 6;

  // frame[0] is the start bit, frame[8:1] the data LSB first, then parity/stop
  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tvalid = 1'b0;
  logic [7:0] tdata = 8'h00;
  logic       tready;
  logic       uartTx;
  logic       busy;

  int total = 0;
  int bad = 0;
  int cycleCnt = 0;
  vec_t vecs[NVEC];

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_tvalid  (tvalid),
    .i_tdata   (tdata),
    .o_tready  (tready),
    .o_uart_tx (uartTx),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Must be entered just after a rising edge; returns 1 time unit after the accepting edge.
  task automatic applyStimulus(input logic [7:0] d, output int acceptCycle);
    bit done;
    logic r;
    done = 1'b0;
    acceptCycle = -1;
    tvalid = 1'b1;
    tdata = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      r = tready;
      @(posedge clk);
      if (r) done = 1'b1;
    end
    #1;
    if (done) begin
      acceptCycle = cycleCnt;
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: byte %0h got no accept, expected accept within 200 cycles", d);
    end
  endtask

  task automatic expectFrame(input logic [10:0] frame, input string name, input bit toggle);
    for (int k = 0; k < FRAME_BITS * CPB; k++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("%s_bit%0d_cyc%0d", name, k / CPB, k), {31'd0, uartTx}, {31'd0, frame[k / CPB]});
      if (toggle) tdata = 8'($urandom);
    end
  endtask

  task automatic runVector(input int i);
    int c;
    applyStimulus(vecs[i].data, c);
    tvalid = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("vec%0d_idle_before_start", i), {31'd0, uartTx}, 32'd1);
    checkOutput($sformatf("vec%0d_busy_held", i), {31'd0, busy}, 32'd1);
    expectFrame(vecs[i].frame, $sformatf("vec%0d", i), 1'b1);
    @(negedge clk);
    checkOutput($sformatf("vec%0d_end_tx", i), {31'd0, uartTx}, 32'd1);
    checkOutput($sformatf("vec%0d_end_busy", i), {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c1, c2, c3;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'b1_0_10100101_0};
    vecs[1] = '{8'h00, 11'b1_0_00000000_0};
    vecs[2] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[3] = '{8'h3C, 11'b1_0_00111100_0};
    vecs[4] = '{8'h07, 11'b1_1_00000111_0};
    vecs[5] = '{8'h03, 11'b1_0_00000011_0};
`else
    vecs[0] = '{8'hA5, 11'b1_1_10100101_0};
    vecs[1] = '{8'h00, 11'b1_1_00000000_0};
    vecs[2] = '{8'hFF, 11'b1_1_11111111_0};
    vecs[3] = '{8'h3C, 11'b1_1_00111100_0};
    vecs[4] = '{8'h07, 11'b1_1_00000111_0};
    vecs[5] = '{8'h03, 11'b1_1_00000011_0};
`endif

    $display("[TB] reset state");
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_tx", {31'd0, uartTx}, 32'd1);
    checkOutput("reset_tready", {31'd0, tready}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single-byte vectors");
    for (int i = 0; i < NVEC; i++) runVector(i);

    $display("[TB] back-to-back 00 then FF");
    applyStimulus(8'h00, c1);
    fork
      begin
        applyStimulus(8'hFF, c2);
        tvalid = 1'b0;
        checkOutput("b2b_accept_gap", 32'(c2 - c1), 32'd2);
      end
      begin
        @(negedge clk);
        checkOutput("b2b_tready_held", {31'd0, tready}, 32'd0);
      end
      begin
        expectFrame(vecs[1].frame, "b2b0", 1'b0);
        expectFrame(vecs[2].frame, "b2b1", 1'b0);
      end
    join
    @(negedge clk);
    checkOutput("b2b_end_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] backpressure with three bytes");
    applyStimulus(vecs[3].data, c1);
    fork
      begin
        applyStimulus(vecs[0].data, c2);
        applyStimulus(vecs[4].data, c3);
        tvalid = 1'b0;
        checkOutput("bp_second_accept", 32'(c2 - c1), 32'd2);
        checkOutput("bp_third_accept", 32'(c3 - c1), 32'(FRAME_BITS * CPB + 2));
      end
      begin
        expectFrame(vecs[3].frame, "bp0", 1'b0);
        expectFrame(vecs[0].frame, "bp1", 1'b0);
        expectFrame(vecs[4].frame, "bp2", 1'b0);
      end
    join
    @(negedge clk);
    checkOutput("bp_end_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] reset during data bit 3");
    applyStimulus(8'hA5, c1);
    applyStimulus(8'h07, c2);
    tvalid = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    checkOutput("mid_bit3_low", {31'd0, uartTx}, 32'd0);
    rstn = 1'b0;
    #1;
    checkOutput("mid_reset_tx", {31'd0, uartTx}, 32'd1);
    checkOutput("mid_reset_tready", {31'd0, tready}, 32'd1);
    checkOutput("mid_reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("post_reset_held_dropped", {31'd0, busy}, 32'd0);
    checkOutput("post_reset_tx", {31'd0, uartTx}, 32'd1);
    @(posedge clk);
    #1;
    runVector(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
